mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_access_unit_lane_unit.sv | 49 ++++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: request op codes,
// controller states and the address-alignment field widths.
package mem_pkg;

  // CPU request operation encoding (req_op)
  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_t;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  // Low address bits that must be zero for word / halfword accesses
  localparam int WORD_OFF_W = 2;
  localparam int HALF_OFF_W = 1;

  // True for the three store operations
  function automatic logic is_store(input mem_op_t op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_unit.sv
// Combinational lane logic: merges a store halfword/byte into a read word
// and extracts/extends a load result from a word (little-endian lanes).
module lane_unit
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  mem_op_t     op_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign op_s = mem_op_t'(op);

  // Pick the addressed byte and halfword lanes out of the word
  always_comb begin
    byte_s = word[{byte_off, 3'b000} +: 8];
    half_s = word[{byte_off[1], 4'b0000} +: 16];
  end

  // Store path: replace only the addressed lane, keep the rest of the word
  always_comb begin
    merged = word;
    case (op_s)
      OP_SH:   merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      OP_SB:   merged[{byte_off, 3'b000} +: 8]      = wdata[7:0];
      default: merged = word;
    endcase
  end

  // Load path: sign-extend LH/LB, zero-extend LHU/LBU
  always_comb begin
    load_data = 32'h0000_0000;
    case (op_s)
      OP_LW:   load_data = word;
      OP_LH:   load_data = {{16{half_s[15]}}, half_s};
      OP_LHU:  load_data = {16'h0000, half_s};
      OP_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  load_data = {24'h00_0000, byte_s};
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request/response port and a single-port
// word memory with combinational read. Sub-word stores are done as
// read-modify-write. All memory-side and response outputs are decoded from
// registered state only, so reset clears them asynchronously.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  mem_state_t        state_r, state_nxt_s;
  mem_op_t           op_r, req_op_s;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r, word_r;
  logic              err_r;
  logic              align_err_s, range_err_s, req_err_s, accept_s;
  logic [31:0]       word_idx_s, merged_s, load_s;

  assign req_op_s    = mem_op_t'(req_op);
  assign accept_s    = (state_r == IDLE) && req_valid;
  assign range_err_s = (req_addr >> 2) >= ADDR_W'(MEM_WORDS);
  assign req_err_s   = align_err_s || range_err_s;
  assign word_idx_s  = 32'(addr_r >> 2);

  // Alignment check on the incoming request
  always_comb begin
    align_err_s = 1'b0;
    case (req_op_s)
      OP_LH, OP_LHU, OP_SH: align_err_s = (req_addr[HALF_OFF_W-1:0] != '0);
      OP_LW, OP_SW:         align_err_s = (req_addr[WORD_OFF_W-1:0] != '0);
      default:              align_err_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: errors skip memory, SW writes directly, SH/SB read first
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!req_valid) begin
          state_nxt_s = IDLE;
        end else if (req_err_s) begin
          state_nxt_s = RESP;
        end else if (req_op_s == OP_SW) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = READ;
        end
      end
      READ: begin
        if (is_store(op_r)) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      WRITE: state_nxt_s = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Latch the request on acceptance and capture the memory word in READ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r    <= OP_LW;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
      word_r  <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        op_r    <= req_op_s;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        err_r   <= req_err_s;
      end
      if (state_r == READ) begin
        word_r <= mem_dout;
      end
    end
  end

  lane_unit u_lane (
    .op        (op_r),
    .byte_off  (addr_r[1:0]),
    .word      (word_r),
    .wdata     (wdata_r),
    .merged    (merged_s),
    .load_data (load_s)
  );

  // Output decode from registered state and latched request
  always_comb begin
    req_ready  = (state_r == IDLE);
    resp_valid = (state_r == RESP);
    mem_we     = (state_r == WRITE);
    if ((state_r == READ) || (state_r == WRITE)) begin
      mem_addr = word_idx_s;
    end else begin
      mem_addr = 32'h0000_0000;
    end
    if (state_r != WRITE) begin
      mem_din = 32'h0000_0000;
    end else if (op_r == OP_SW) begin
      mem_din = wdata_r;
    end else begin
      mem_din = merged_s;
    end
    if ((state_r == RESP) && !err_r && !is_store(op_r)) begin
      resp_rdata = load_s;
    end else begin
      resp_rdata = 32'h0000_0000;
    end
    resp_err = (state_r == RESP) && err_r;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory and a
// scoreboard of expected responses (data, error flag, latency).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [31:0] pre_val = 32'h0;
  int          we_cnt = 0;
  logic [31:0] we_addr = 32'h0;

  mem_access_unit #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_din;
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge
  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); @(negedge clk);
    pre_en = 1'b0;
  endtask

  // One full transaction; called at a negedge, returns at a negedge
  task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat, input int hold,
                        input int exp_we);
    exp_t e;
    int   we0;
    int   lat;
    e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb_q.push_back(e);
    chk1({tag, "_req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    we0 = we_cnt;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk1({tag, "_resp_valid"}, resp_valid, 1'b1);
    e = sb_q.pop_front();
    chk32({tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk32({tag, "_rdata"}, resp_rdata, e.rd);
    chk1({tag, "_err"}, resp_err, e.err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1({tag, "_hold_valid"}, resp_valid, 1'b1);
      chk32({tag, "_hold_rdata"}, resp_rdata, e.rd);
      chk1({tag, "_hold_err"}, resp_err, e.err);
      chk1({tag, "_hold_ready"}, req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    chk1({tag, "_retired"}, resp_valid, 1'b0);
    chk1({tag, "_ready_after"}, req_ready, 1'b1);
    chk32({tag, "_we_count"}, 32'(we_cnt - we0), 32'(exp_we));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int we0;
    // Reset values while reset is held
    #1;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // SW then LW at word 4
    do_req("sw10", 3'd5, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
    chk32("sw10_we_addr", we_addr, 32'd4);
    chk32("sw10_mem", mem[4], 32'hDEADBEEF);
    do_req("lw10", 3'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 0);

    // SB read-modify-write
    preload(10'd4, 32'h11223344);
    do_req("sb12", 3'd7, 32'h12, 32'h000000AB, 32'h0, 1'b0, 3, 0, 1);
    chk32("sb12_mem", mem[4], 32'h11AB3344);

    // Sub-word loads with extension
    preload(10'd4, 32'h8000FF7F);
    do_req("lb10",  3'd3, 32'h10, 32'h0, 32'h0000007F, 1'b0, 2, 0, 0);
    do_req("lbu11", 3'd4, 32'h11, 32'h0, 32'h000000FF, 1'b0, 2, 0, 0);
    do_req("lh12",  3'd1, 32'h12, 32'h0, 32'hFFFF8000, 1'b0, 2, 0, 0);
    do_req("lhu12", 3'd2, 32'h12, 32'h0, 32'h00008000, 1'b0, 2, 0, 0);
    do_req("sh12",  3'd6, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 3, 0, 1);
    chk32("sh12_mem", mem[4], 32'h1234FF7F);

    // Error cases: misaligned and out of range
    do_req("err_lw13",   3'd0, 32'h13,   32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("err_sh11",   3'd6, 32'h11,   32'h5555, 32'h0, 1'b1, 1, 0, 0);
    do_req("err_lw1000", 3'd0, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    chk32("err_mem_intact", mem[4], 32'h1234FF7F);

    // Response back-pressure for 5 cycles
    do_req("lw_hold", 3'd0, 32'h10, 32'h0, 32'h1234FF7F, 1'b0, 2, 5, 0);

    // Reset during READ of an SB
    preload(10'd4, 32'hCAFE0123);
    we0 = we_cnt;
    req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h12; req_wdata = 32'hAB;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk32("rmw_read_addr", mem_addr, 32'd4);
    chk1("rmw_read_we", mem_we, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk1("rstr_req_ready", req_ready, 1'b1);
    chk1("rstr_resp_valid", resp_valid, 1'b0);
    chk1("rstr_resp_err", resp_err, 1'b0);
    chk32("rstr_resp_rdata", resp_rdata, 32'h0);
    chk1("rstr_mem_we", mem_we, 1'b0);
    chk32("rstr_mem_din", mem_din, 32'h0);
    chk32("rstr_mem_addr", mem_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk32("rstr_mem_word", mem[4], 32'hCAFE0123);
    chk32("rstr_we_count", 32'(we_cnt - we0), 32'd0);

    // Reset during WRITE of an SW: mem_we drops at once, no write lands
    preload(10'd5, 32'h00000005);
    we0 = we_cnt;
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h14; req_wdata = 32'h99;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk1("rstw_we_before", mem_we, 1'b1);
    chk32("rstw_din_before", mem_din, 32'h99);
    #1 reset = 1'b1;
    #1;
    chk1("rstw_we_after", mem_we, 1'b0);
    chk32("rstw_addr_after", mem_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk32("rstw_mem_word", mem[5], 32'h00000005);
    chk32("rstw_we_count", 32'(we_cnt - we0), 32'd0);

    // Acceptance at the first edge after reset release
    do_req("lw_post_rst", 3'd0, 32'h10, 32'h0, 32'hCAFE0123, 1'b0, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
